translation_overlay: RTL and testbench

- Single-clock overlay core between the Game Boy video path and the platform video output.
- Snoops VRAM tile-map writes and assembles runs of tile codes into words, hashing each word.
- Checks each hash against a loadable bloom filter and a loadable dictionary.
- On a hit, fetches a 160x8 caption bitmap from external memory and draws it over the video; in mode 1 it instead emits a tile-replacement request.

---
 rtl/translation_overlay.sv | 263 ++++++++++++++++++++++++++
 tb/tb_translation_overlay.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/translation_overlay.sv
// Snoops Game Boy tile-map writes, hashes tile runs into words and looks them up in a
// bloom filter plus dictionary; a hit either overlays a fetched caption or requests a tile swap.
module translation_overlay #(
  parameter logic [7:0] TERM_TILE = 8'h00,
  parameter int         MAX_TILES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vram_we,
  input  logic [12:0] vram_addr,
  input  logic [7:0]  vram_wdata,
  input  logic [14:0] vid_rgb_in,
  input  logic        vid_de_in,
  input  logic        vid_vs_in,
  input  logic        vid_hs_in,
  input  logic [7:0]  vid_x,
  input  logic [7:0]  vid_y,
  output logic [14:0] vid_rgb_out,
  output logic        vid_de_out,
  output logic        vid_vs_out,
  output logic        vid_hs_out,
  output logic        vram_replace_en,
  output logic [20:0] vram_replace_data,
  output logic        ext_mem_rd,
  output logic [23:0] ext_mem_addr,
  input  logic [31:0] ext_mem_rdata,
  input  logic        ext_mem_rvalid,
  input  logic        dict_load_en,
  input  logic [15:0] dict_load_addr,
  input  logic [40:0] dict_load_data,
  input  logic        bloom_load_en,
  input  logic [15:0] bloom_load_addr,
  input  logic        bloom_load_bit,
  input  logic        cfg_enable,
  input  logic        cfg_mode,
  input  logic [14:0] cfg_caption_color,
  input  logic [7:0]  cfg_caption_y
);
  localparam int               LEN_W     = $clog2(MAX_TILES + 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_TILES);
  localparam int               CAP_WORDS = 40;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;

  // ---------------- word accumulation ----------------
  logic [15:0]      h_reg, h_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [12:0]      start_reg, start_next;
  logic [12:0]      last_reg, last_next;
  logic             vs_q;
  logic             snoop, vs_rise, end_evt, empty_eff;
  logic [15:0]      h_base;
  logic [LEN_W-1:0] len_base;

  assign snoop   = vram_we && (vram_addr[12:11] == 2'b11);
  assign vs_rise = vid_vs_in && !vs_q;

  always_comb begin
    h_next     = h_reg;
    len_next   = len_reg;
    start_next = start_reg;
    last_next  = last_reg;
    end_evt    = 1'b0;
    empty_eff  = (len_reg == '0);
    if (vs_rise && !empty_eff) begin
      end_evt   = 1'b1;
      empty_eff = 1'b1;
      h_next    = '0;
      len_next  = '0;
    end
    h_base   = empty_eff ? 16'h0000 : h_reg;
    len_base = empty_eff ? '0 : len_reg;
    if (snoop) begin
      if (vram_wdata == TERM_TILE) begin
        if (!empty_eff) begin
          end_evt  = 1'b1;
          h_next   = '0;
          len_next = '0;
        end
      end else begin
        // A gap in the address run closes the current word; this tile opens the next one.
        if (!empty_eff && (vram_addr != last_reg + 13'd1)) begin
          end_evt  = 1'b1;
          h_base   = '0;
          len_base = '0;
        end
        if (len_base == '0) start_next = vram_addr;
        last_next = vram_addr;
        h_next    = (len_base < LEN_MAX) ? ({h_base[14:0], h_base[15]} ^ {8'h00, vram_wdata}) : h_base;
        len_next  = (len_base == LEN_MAX) ? len_base : len_base + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg     <= '0;
      len_reg   <= '0;
      start_reg <= '0;
      last_reg  <= '0;
    end else begin
      h_reg     <= h_next;
      len_reg   <= len_next;
      start_reg <= start_next;
      last_reg  <= last_next;
    end
  end

  // ---------------- lookup pipeline ----------------
  logic        s1_v, s2_v, s3_v, busy;
  logic [15:0] lk_hash;
  logic [12:0] lk_start;
  logic        bloom_mem [0:65535];
  logic [40:0] dict_mem  [0:1023];
  logic        bloom_bit_q;
  logic [40:0] dict_q;
  logic        hit, hit_act;
  logic        unused_dict_addr;

  assign busy             = s1_v | s2_v | s3_v;
  assign unused_dict_addr = ^dict_load_addr[15:10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s3_v     <= 1'b0;
      lk_hash  <= '0;
      lk_start <= '0;
    end else begin
      s1_v <= end_evt && !busy;
      if (end_evt && !busy) begin
        lk_hash  <= h_reg;
        lk_start <= start_reg;
      end
      s2_v <= s1_v;
      s3_v <= s2_v && bloom_bit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (bloom_load_en) bloom_mem[bloom_load_addr] <= bloom_load_bit;
    bloom_bit_q <= bloom_mem[lk_hash];
  end

  always_ff @(posedge clk) begin
    if (dict_load_en) dict_mem[dict_load_addr[9:0]] <= dict_load_data;
    if (s2_v && bloom_bit_q) dict_q <= dict_mem[lk_hash[9:0]];
  end

  assign hit     = s3_v && dict_q[40] && (dict_q[39:24] == lk_hash);
  assign hit_act = hit && cfg_enable;

  // ---------------- hit actions and caption fetch ----------------
  fetch_state_t state_reg, state_next;
  logic [5:0]   idx_reg, idx_next;
  logic [23:0]  base_reg, base_next;
  logic         fetch_start, cap_we, cap_done;
  logic         caption_valid_reg;
  logic         replace_en_reg;
  logic [20:0]  replace_data_reg;

  assign fetch_start = hit_act && !cfg_mode && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    base_next  = base_reg;
    cap_we     = 1'b0;
    cap_done   = 1'b0;
    case (state_reg)
      IDLE: if (fetch_start) begin
        base_next  = dict_q[23:0];
        idx_next   = '0;
        state_next = REQ;
      end
      REQ: state_next = WAIT;
      WAIT: if (ext_mem_rvalid) begin
        cap_we = 1'b1;
        if (idx_reg == 6'(CAP_WORDS - 1)) begin
          cap_done   = 1'b1;
          state_next = IDLE;
        end else begin
          idx_next   = idx_reg + 6'd1;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      idx_reg           <= '0;
      base_reg          <= '0;
      caption_valid_reg <= 1'b0;
      replace_en_reg    <= 1'b0;
      replace_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      base_reg  <= base_next;
      if (fetch_start)   caption_valid_reg <= 1'b0;
      else if (cap_done) caption_valid_reg <= 1'b1;
      replace_en_reg <= hit_act && cfg_mode;
      if (hit_act && cfg_mode) replace_data_reg <= {lk_start, dict_q[7:0]};
    end
  end

  assign ext_mem_rd        = (state_reg == REQ);
  assign ext_mem_addr      = base_reg + 24'(idx_reg);
  assign vram_replace_en   = replace_en_reg;
  assign vram_replace_data = replace_data_reg;

  // ---------------- caption buffer and video path ----------------
  logic [31:0] cap_mem [0:CAP_WORDS-1];
  logic [31:0] cap_word_q;
  logic [7:0]  cap_row;
  logic        cap_region;
  logic [10:0] cap_idx;
  logic [5:0]  cap_word_sel;
  logic [14:0] rgb_q, color_q;
  logic        de_q, hs_q, region_q;
  logic [4:0]  bit_sel_q;

  assign cap_row    = vid_y - cfg_caption_y;
  assign cap_region = cfg_enable && !cfg_mode && caption_valid_reg && vid_de_in &&
                      (vid_y >= cfg_caption_y) && (cap_row < 8'd8) && (vid_x < 8'd160);
  assign cap_idx    = 11'(cap_row[2:0]) * 11'd160 + 11'(vid_x);
  // Outside the region the index can run past the buffer; keep the read in range.
  assign cap_word_sel = (cap_idx[10:5] < 6'(CAP_WORDS)) ? cap_idx[10:5] : 6'd0;

  always_ff @(posedge clk) begin
    if (cap_we) cap_mem[idx_reg] <= ext_mem_rdata;
    cap_word_q <= cap_mem[cap_word_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q     <= '0;
      de_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      region_q  <= 1'b0;
      bit_sel_q <= '0;
      color_q   <= '0;
    end else begin
      rgb_q     <= vid_rgb_in;
      de_q      <= vid_de_in;
      vs_q      <= vid_vs_in;
      hs_q      <= vid_hs_in;
      region_q  <= cap_region;
      bit_sel_q <= cap_idx[4:0];
      color_q   <= cfg_caption_color;
    end
  end

  assign vid_rgb_out = region_q ? (cap_word_q[bit_sel_q] ? color_q : 15'h0000) : rgb_q;
  assign vid_de_out  = de_q;
  assign vid_vs_out  = vs_q;
  assign vid_hs_out  = hs_q;
endmodule

// File: tb/tb_translation_overlay.sv
// Self-checking bench for translation_overlay: vector tables, hand sequences for lookup/fetch
// corners, and randomized words checked against a spec-level hash/lookup model.
module tb_translation_overlay;
  localparam logic [7:0]  TERM      = 8'h00;
  localparam int          MAXT      = 8;
  localparam logic [14:0] CAP_COLOR = 15'h7C1F;

  logic        clk = 1'b0, rst = 1'b1;
  logic        vram_we = 1'b0;
  logic [12:0] vram_addr = '0;
  logic [7:0]  vram_wdata = '0;
  logic [14:0] vid_rgb_in = '0;
  logic        vid_de_in = 1'b0, vid_vs_in = 1'b0, vid_hs_in = 1'b0;
  logic [7:0]  vid_x = '0, vid_y = '0;
  logic [14:0] vid_rgb_out;
  logic        vid_de_out, vid_vs_out, vid_hs_out;
  logic        vram_replace_en;
  logic [20:0] vram_replace_data;
  logic        ext_mem_rd;
  logic [23:0] ext_mem_addr;
  logic [31:0] ext_mem_rdata = '0;
  logic        ext_mem_rvalid = 1'b0;
  logic        dict_load_en = 1'b0;
  logic [15:0] dict_load_addr = '0;
  logic [40:0] dict_load_data = '0;
  logic        bloom_load_en = 1'b0;
  logic [15:0] bloom_load_addr = '0;
  logic        bloom_load_bit = 1'b0;
  logic        cfg_enable = 1'b0, cfg_mode = 1'b0;
  logic [14:0] cfg_caption_color = CAP_COLOR;
  logic [7:0]  cfg_caption_y = 8'd50;

  always #5 clk = ~clk;

  translation_overlay #(.TERM_TILE(TERM), .MAX_TILES(MAXT)) dut (
    .clk(clk), .rst(rst),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vid_rgb_in(vid_rgb_in), .vid_de_in(vid_de_in), .vid_vs_in(vid_vs_in), .vid_hs_in(vid_hs_in),
    .vid_x(vid_x), .vid_y(vid_y),
    .vid_rgb_out(vid_rgb_out), .vid_de_out(vid_de_out), .vid_vs_out(vid_vs_out), .vid_hs_out(vid_hs_out),
    .vram_replace_en(vram_replace_en), .vram_replace_data(vram_replace_data),
    .ext_mem_rd(ext_mem_rd), .ext_mem_addr(ext_mem_addr),
    .ext_mem_rdata(ext_mem_rdata), .ext_mem_rvalid(ext_mem_rvalid),
    .dict_load_en(dict_load_en), .dict_load_addr(dict_load_addr), .dict_load_data(dict_load_data),
    .bloom_load_en(bloom_load_en), .bloom_load_addr(bloom_load_addr), .bloom_load_bit(bloom_load_bit),
    .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_caption_color(cfg_caption_color), .cfg_caption_y(cfg_caption_y)
  );

  int          n_checks = 0, n_pass = 0;
  logic [23:0] rd_log[$];
  logic [20:0] rep_log[$];
  int          mem_delay = 0;
  logic [23:0] mem_pend = '0;
  logic [7:0]  tl [16];
  logic [31:0] cap_model [40];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Word hash straight from the rule: rotate-left then xor each tile, first MAXT tiles only.
  function automatic logic [15:0] word_hash(input int n);
    logic [15:0] h = 16'h0000;
    for (int i = 0; i < n && i < MAXT; i++) h = {h[14:0], h[15]} ^ {8'h00, tl[i]};
    return h;
  endfunction

  function automatic logic [14:0] exp_pixel(input int x, input int y, input int cy,
                                            input logic de, input logic [14:0] rgb, input logic cap_on);
    int idx;
    logic [31:0] w;
    if (cap_on && de && y >= cy && (y - cy) < 8 && x < 160) begin
      idx = (y - cy) * 160 + x;
      w = cap_model[idx / 32];
      return w[idx % 32] ? CAP_COLOR : 15'h0000;
    end
    return rgb;
  endfunction

  // External memory responder and output monitor, sampled late in each cycle.
  initial begin
    forever begin
      @(posedge clk); #2;
      ext_mem_rvalid = 1'b0;
      if (mem_delay > 0) begin
        mem_delay--;
        if (mem_delay == 0) begin
          ext_mem_rvalid = 1'b1;
          ext_mem_rdata  = mem_word(mem_pend);
        end
      end
      if (ext_mem_rd === 1'b1) begin
        rd_log.push_back(ext_mem_addr);
        mem_pend  = ext_mem_addr;
        mem_delay = 2;
      end
      if (vram_replace_en === 1'b1) rep_log.push_back(vram_replace_data);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic vram_write(input logic [12:0] a, input logic [7:0] d);
    vram_we = 1'b1; vram_addr = a; vram_wdata = d;
    step();
    vram_we = 1'b0;
  endtask

  task automatic write_word(input logic [12:0] start, input int n);
    for (int i = 0; i < n; i++) vram_write(start + 13'(i), tl[i]);
  endtask

  task automatic load_bloom(input logic [15:0] a, input logic b);
    bloom_load_en = 1'b1; bloom_load_addr = a; bloom_load_bit = b;
    step();
    bloom_load_en = 1'b0;
  endtask

  task automatic load_dict(input logic [9:0] a, input logic [40:0] d);
    dict_load_en = 1'b1; dict_load_addr = {6'd0, a}; dict_load_data = d;
    step();
    dict_load_en = 1'b0;
  endtask

  typedef struct {
    logic [14:0] rgb; logic de; logic vs; logic hs;
    logic [17:0] exp;
  } pt_vec_t;

  typedef struct {
    int x; int y; int cy; logic de; logic [14:0] rgb;
    logic [14:0] exp;
  } pix_vec_t;

  initial begin
    pt_vec_t     ptv [6];
    pix_vec_t    pv  [12];
    logic [15:0] h, h1, h2;
    int          first_rd, sz, n, kind;
    logic        en;
    logic [12:0] st;
    logic [23:0] payload;

    // ---- reset state ----
    idle(2);
    check("rst_rgb", vid_rgb_out, 0);
    check("rst_de", vid_de_out, 0);
    check("rst_vs", vid_vs_out, 0);
    check("rst_hs", vid_hs_out, 0);
    check("rst_rep_en", vram_replace_en, 0);
    check("rst_rep_data", vram_replace_data, 0);
    check("rst_rd", ext_mem_rd, 0);
    check("rst_addr", ext_mem_addr, 0);
    rst = 1'b0;
    idle(1);

    // ---- passthrough table ----
    ptv[0] = '{15'h1234, 1'b1, 1'b0, 1'b0, {15'h1234, 3'b100}};
    ptv[1] = '{15'h7FFF, 1'b1, 1'b0, 1'b1, {15'h7FFF, 3'b101}};
    ptv[2] = '{15'h0000, 1'b0, 1'b1, 1'b0, {15'h0000, 3'b010}};
    ptv[3] = '{15'h2AAA, 1'b0, 1'b0, 1'b0, {15'h2AAA, 3'b000}};
    ptv[4] = '{15'h5555, 1'b1, 1'b1, 1'b1, {15'h5555, 3'b111}};
    ptv[5] = '{15'h0F0F, 1'b1, 1'b0, 1'b0, {15'h0F0F, 3'b100}};
    for (int i = 0; i < 6; i++) begin
      vid_rgb_in = ptv[i].rgb; vid_de_in = ptv[i].de; vid_vs_in = ptv[i].vs; vid_hs_in = ptv[i].hs;
      step();
      $display("pass vec %0d rgb=%h out=%h", i, ptv[i].rgb, vid_rgb_out);
      check("passthrough", {vid_rgb_out, vid_de_out, vid_vs_out, vid_hs_out}, ptv[i].exp);
      if (i == 0) check("pass_side_outs", {vram_replace_en, ext_mem_rd}, 0);
    end
    vid_vs_in = 1'b0; vid_hs_in = 1'b0; vid_de_in = 1'b0;
    idle(2);

    // ---- caption hit ----
    cfg_enable = 1'b1; cfg_mode = 1'b0; cfg_caption_y = 8'd50;
    tl[0] = 8'h21; tl[1] = 8'h22;
    h = word_hash(2);
    load_bloom(h, 1'b1);
    load_dict(h[9:0], {1'b1, h, 24'h000100});
    rd_log.delete();
    write_word(13'h1800, 2);
    vram_write(13'h1802, TERM);
    first_rd = -1;
    for (int k = 0; k < 6; k++) begin
      if (ext_mem_rd === 1'b1 && first_rd < 0) first_rd = k;
      step();
    end
    check("hit_latency", first_rd, 3);
    for (int c = 0; c < 2000 && rd_log.size() < 40; c++) step();
    idle(8);
    $display("caption fetch h=%h reads=%0d", h, rd_log.size());
    check("fetch_count", rd_log.size(), 40);
    sz = 0;
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== 24'h100 + 24'(i)) sz++;
    check("fetch_addr_seq", sz, 0);
    for (int i = 0; i < 40; i++) cap_model[i] = mem_word(24'h100 + 24'(i));

    // ---- caption pixel table (boundaries) ----
    pv[0]  = '{0,   50,  50,  1'b1, 15'h1111, 15'h0};
    pv[1]  = '{159, 50,  50,  1'b1, 15'h1112, 15'h0};
    pv[2]  = '{160, 50,  50,  1'b1, 15'h1113, 15'h0};
    pv[3]  = '{31,  51,  50,  1'b1, 15'h1114, 15'h0};
    pv[4]  = '{32,  52,  50,  1'b1, 15'h1115, 15'h0};
    pv[5]  = '{5,   57,  50,  1'b1, 15'h1116, 15'h0};
    pv[6]  = '{5,   58,  50,  1'b1, 15'h1117, 15'h0};
    pv[7]  = '{5,   49,  50,  1'b1, 15'h1118, 15'h0};
    pv[8]  = '{100, 53,  50,  1'b0, 15'h1119, 15'h0};
    pv[9]  = '{10,  255, 250, 1'b1, 15'h111A, 15'h0};
    pv[10] = '{10,  1,   250, 1'b1, 15'h111B, 15'h0};
    pv[11] = '{0,   250, 250, 1'b1, 15'h111C, 15'h0};
    for (int i = 0; i < 12; i++) pv[i].exp = exp_pixel(pv[i].x, pv[i].y, pv[i].cy, pv[i].de, pv[i].rgb, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cfg_caption_y = 8'(pv[i].cy); vid_x = 8'(pv[i].x); vid_y = 8'(pv[i].y);
      vid_de_in = pv[i].de; vid_rgb_in = pv[i].rgb;
      step();
      $display("pix x=%0d y=%0d cy=%0d out=%h", pv[i].x, pv[i].y, pv[i].cy, vid_rgb_out);
      check("caption_pix_edge", vid_rgb_out, pv[i].exp);
    end

    // ---- random caption pixels ----
    cfg_caption_y = 8'd50;
    for (int i = 0; i < 40; i++) begin
      int rx, ry;
      logic rde;
      logic [14:0] rrgb;
      rx = $urandom_range(0, 200); ry = 48 + $urandom_range(0, 11);
      rde = ($urandom_range(0, 3) != 0); rrgb = 15'($urandom);
      vid_x = 8'(rx); vid_y = 8'(ry); vid_de_in = rde; vid_rgb_in = rrgb;
      step();
      check("caption_pix_rand", vid_rgb_out, exp_pixel(rx, ry, 50, rde, rrgb, 1'b1));
    end
    cfg_enable = 1'b0; vid_x = 8'd3; vid_y = 8'd52; vid_de_in = 1'b1; vid_rgb_in = 15'h0ABC;
    step();
    check("caption_disabled", vid_rgb_out, 15'h0ABC);
    cfg_enable = 1'b1; vid_de_in = 1'b0;

    // ---- bloom miss ----
    load_bloom(h, 1'b0);
    rd_log.delete(); rep_log.delete();
    write_word(13'h1800, 2); vram_write(13'h1802, TERM);
    idle(12);
    $display("bloom miss reads=%0d reps=%0d", rd_log.size(), rep_log.size());
    check("miss_no_rd", rd_log.size(), 0);
    check("miss_no_rep", rep_log.size(), 0);

    // ---- key mismatch ----
    load_bloom(h, 1'b1);
    load_dict(h[9:0], {1'b1, 16'h0063, 24'h000100});
    write_word(13'h1800, 2); vram_write(13'h1802, TERM);
    idle(12);
    $display("key mismatch reads=%0d reps=%0d", rd_log.size(), rep_log.size());
    check("mismatch_no_rd", rd_log.size(), 0);
    check("mismatch_no_rep", rep_log.size(), 0);

    // ---- mode 1 replace ----
    load_dict(h[9:0], {1'b1, h, 24'h000100});
    cfg_mode = 1'b1;
    write_word(13'h1800, 2); vram_write(13'h1802, TERM);
    idle(12);
    $display("mode1 reps=%0d", rep_log.size());
    check("mode1_one_pulse", rep_log.size(), 1);
    if (rep_log.size() > 0) check("mode1_data", rep_log[0], {13'h1800, 8'h00});
    check("mode1_no_rd", rd_log.size(), 0);

    // ---- non-consecutive split, busy drop, vsync end ----
    tl[0] = 8'h21; h1 = word_hash(1);
    tl[0] = 8'h33; tl[1] = 8'h34; h2 = word_hash(2);
    load_bloom(h1, 1'b1); load_dict(h1[9:0], {1'b1, h1, 24'h0000A1});
    load_bloom(h2, 1'b1); load_dict(h2[9:0], {1'b1, h2, 24'h0000B2});
    load_bloom(16'h0033, 1'b1); load_dict(10'h033, {1'b1, 16'h0033, 24'h0000C3});
    rep_log.delete();
    vram_write(13'h1800, 8'h21);
    vram_write(13'h1805, 8'h33);
    vram_write(13'h1806, 8'h34);
    idle(4);
    vram_write(13'h1807, TERM);
    idle(10);
    $display("split reps=%0d", rep_log.size());
    check("split_count", rep_log.size(), 2);
    if (rep_log.size() > 1) begin
      check("split_first", rep_log[0], {13'h1800, 8'hA1});
      check("split_second", rep_log[1], {13'h1805, 8'hB2});
    end

    rep_log.delete();
    vram_write(13'h1800, 8'h21);
    vram_write(13'h1805, 8'h33);
    vram_write(13'h1806, TERM);
    idle(10);
    $display("busy drop reps=%0d", rep_log.size());
    check("drop_count", rep_log.size(), 1);
    if (rep_log.size() > 0) check("drop_kept", rep_log[0], {13'h1800, 8'hA1});

    rep_log.delete();
    vram_write(13'h1810, 8'h21);
    vid_vs_in = 1'b1; step(); vid_vs_in = 1'b0;
    idle(10);
    $display("vsync end reps=%0d", rep_log.size());
    check("vs_count", rep_log.size(), 1);
    if (rep_log.size() > 0) check("vs_data", rep_log[0], {13'h1810, 8'hA1});

    // ---- randomized words against the model ----
    for (int t = 0; t < 16; t++) begin
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) tl[i] = 8'($urandom_range(1, 255));
      st = 13'h1800 + 13'($urandom_range(0, 12'h7F0));
      kind = $urandom_range(0, 3);
      en = ($urandom_range(0, 3) != 0);
      payload = 24'($urandom);
      h = word_hash(n);
      load_bloom(h, kind > 0);
      load_dict(h[9:0], {kind != 3, (kind == 1) ? (h ^ 16'h0400) : h, payload});
      cfg_enable = en;
      rep_log.delete();
      write_word(st, n);
      if ($urandom_range(0, 1) == 0) vram_write(st + 13'(n), TERM);
      else begin vid_vs_in = 1'b1; step(); vid_vs_in = 1'b0; end
      idle(8);
      $display("rand word start=%h n=%0d h=%h kind=%0d en=%0d reps=%0d", st, n, h, kind, en, rep_log.size());
      check("rand_pulses", rep_log.size(), (kind == 2 && en) ? 1 : 0);
      if (kind == 2 && en && rep_log.size() > 0) check("rand_data", rep_log[0], {st, payload[7:0]});
    end

    // ---- reset during a fetch ----
    cfg_enable = 1'b1; cfg_mode = 1'b0;
    tl[0] = 8'h21; tl[1] = 8'h22; h = word_hash(2);
    load_bloom(h, 1'b1);
    load_dict(h[9:0], {1'b1, h, 24'h000100});
    rd_log.delete();
    write_word(13'h1800, 2); vram_write(13'h1802, TERM);
    for (int c = 0; c < 200 && rd_log.size() < 5; c++) step();
    check("pre_reset_reads", rd_log.size() >= 5, 1);
    rst = 1'b1;
    #1;
    check("async_rst_rd", ext_mem_rd, 0);
    check("async_rst_addr", ext_mem_addr, 0);
    check("async_rst_rgb", vid_rgb_out, 0);
    check("async_rst_rep", vram_replace_en, 0);
    idle(2);
    rst = 1'b0;
    sz = rd_log.size();
    idle(60);
    $display("reset mid-fetch reads before=%0d after=%0d", sz, rd_log.size());
    check("no_rd_after_reset", rd_log.size(), sz);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
